snake_game_ctrl: RTL and testbench
==================================

// Module: snake_game_ctrl
// PURPOSE
//  Game-step sequencer for the 16x16 red/green LED playfield. On each game tick it:
//   - applies the latched direction and computes the new head;
//   - checks wall/self collision and apple capture;
//   - issues per-pixel draw commands to the playfield (new head, recoloured old head, erased tail).
//  Owns snake body coordinates in a circular buffer plus a 256-bit occupancy map.
// PARAMETERS
//  MAX_LEN   default 64  body capacity in cells (power of 2, 4..256)
//  INIT_LEN  default 3   cells drawn after reset (fixed layout below; must equal 3)
// PORTS
//  clk          in   1  clock
//  reset        in   1  synchronous, active-high
//  tick         in   1  one-cycle game-step strobe
//  dir_valid    in   1  direction request strobe
//  dir          in   2  requested dir: 0 UP(y-1) 1 DOWN(y+1) 2 LEFT(x-1) 3 RIGHT(x+1)
//  apple_x      in   4  apple column
//  apple_y      in   4  apple row
//  draw_valid   out  1  draw command pending
//  draw_ready   in   1  playfield accepts command when valid&ready
//  draw_x       out  4  target column
//  draw_y       out  4  target row
//  draw_color   out  2  {red,grn}: 00 off, 01 green (head), 11 yellow (body)
//  head_x       out  4  current head column
//  head_y       out  4  current head row
//  length       out  9  current snake length
//  score        out  8  apples eaten, saturates at 255
//  apple_eaten  out  1  one-cycle pulse on capture
//  busy         out  1  state != IDLE
//  game_over    out  1  sticky until reset
// BEHAVIOUR
//  Reset values: draw_valid 0, head (8,6), length 3, score 0, apple_eaten 0, game_over 0, busy 1.
//  Reset state: INIT; body = head (8,6), (9,6), (10,6); dir LEFT; occupancy holds those 3 cells.
//  FSM: INIT -> IDLE -> STEP -> DRAW_HEAD -> DRAW_BODY -> [ERASE_TAIL] -> IDLE; STEP -> OVER.
//  INIT: issues 3 draws in order (8,6) 01, (9,6) 11, (10,6) 11, then enters IDLE.
//  Direction latch:
//   - dir_valid in any state except OVER latches dir into pending_dir; last request wins.
//   - A request opposite to the current dir is dropped.
//  IDLE: tick -> STEP. A tick in any other state is ignored (no queueing).
//  STEP (1 cycle): cur_dir <= pending_dir; compute nxt head.
//   - grow = (nxt == apple) && length < MAX_LEN.
//   - hit  = occupied[nxt] && !(nxt == tail && !grow). Moving into the vacating tail is legal.
//   - hit -> OVER: game_over = 1, no draws issued.
//   - Otherwise: push nxt at head, set occupancy, update head_x/head_y.
//   - nxt == apple: apple_eaten pulses in this STEP cycle; score += 1 (saturating).
//   - grow: length += 1. At MAX_LEN an apple still scores but does not grow.
//  DRAW_HEAD: (nxt) 01. DRAW_BODY: (old head) 11. ERASE_TAIL (only if !grow): (old tail) 00.
//   - ERASE_TAIL pops the tail and clears its occupancy bit unless tail == nxt.
//  Draw handshake:
//   - draw_* are registered and held stable while draw_valid && !draw_ready.
//   - Advance state on acceptance; draw_valid may stay high back-to-back.
//  Latency (draw_ready=1): tick at cycle T -> STEP T+1, draws T+2..T+4, IDLE at T+5 (T+4 if grow).
//  OVER: absorbing; only reset leaves it. busy = 1.
//  Reset mid-step: abandons any pending draw; returns to INIT. Playfield is cleared by its own reset.
//  Coordinate arithmetic: 4-bit, see CONFIGURATION for edge handling.
// CONFIGURATION
//  SNAKE_WRAP_EN defined:
//   - Moves past an edge wrap mod 16, e.g. x=0 + LEFT -> x=15. Only self-collision ends the game.
//  SNAKE_WRAP_EN undefined:
//   - Any move past an edge is a wall hit -> OVER; the head is not updated.
// STRUCTURE
//  Package snake_pkg:
//   - dir_e {UP,DOWN,LEFT,RIGHT}, coord_t struct {logic [3:0] x, y}, color_e {OFF,GRN,RED,YEL}.
//   - INIT_HEAD_X=8, INIT_HEAD_Y=6, opposite() function.
//  Sub-module snake_body_fifo:
//   - MAX_LEN-deep circular buffer of coord_t.
//   - push_head, pop_tail, head/tail read ports, count.
//   - Reset preloads the 3 initial cells.
//  Top module holds the FSM, occupancy map, direction latch, score and draw register.
// TESTING
//  1 reset, draw_ready=1 -> draws (8,6)01,(9,6)11,(10,6)11; then busy=0, length=3.
//  2 tick with no dir, apple (0,0) -> draws (7,6)01,(8,6)11,(10,6)00; head (7,6); IDLE 5 cycles after tick.
//  3 apple (7,6), tick -> apple_eaten pulse, score 1, length 4, no ERASE_TAIL draw.
//  4 dir RIGHT while moving LEFT -> ignored. dir UP then DOWN before tick -> DOWN used, head (8,7).
//  5 draw_ready=0 for 10 cycles in DRAW_HEAD -> draw_* stable; ticks ignored; sequence resumes.
//  6 steer to x=0, then LEFT: WRAP_EN -> head x=15; without it -> game_over=1, no draws.
//    Also: self-loop into body -> game_over=1.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game-step sequencer.
package snake_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_e;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
    } coord_t;

    // {red, green} pixel colour
    typedef enum logic [1:0] {
        OFF = 2'b00,
        GRN = 2'b01,
        RED = 2'b10,
        YEL = 2'b11
    } color_e;

    localparam logic [3:0] INIT_HEAD_X = 4'd8;
    localparam logic [3:0] INIT_HEAD_Y = 4'd6;

    // Reverse heading: the encoding pairs UP/DOWN and LEFT/RIGHT in bit 0
    function automatic dir_e opposite(input dir_e d);
        return dir_e'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/snake_body_fifo.sv
// Circular buffer of snake body cells. Head is the newest entry, tail the oldest.
// Reset preloads the initial body: head (8,6), then (9,6), tail (10,6).
module snake_body_fifo
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic [7:0] i_push_data,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic [7:0] o_tail,
    output logic [8:0] o_count
);

    localparam int AW = $clog2(MAX_LEN);

    coord_t        r_mem [MAX_LEN];
    logic [AW-1:0] r_head_ptr;
    logic [AW-1:0] r_tail_ptr;
    logic [8:0]    r_count;
    logic [AW-1:0] w_head_nxt;

    assign w_head_nxt = r_head_ptr + AW'(1);

    // Body storage: preload the three starting cells, then write pushes at the new head slot
    always_ff @(posedge clk) begin
        // NOTE: only the live slots are reset; the rest are never read before being written,
        // so leaving them unreset keeps this a plain register file.
        if (reset) begin
            r_mem[0] <= '{x: INIT_HEAD_X + 4'd2, y: INIT_HEAD_Y};
            r_mem[1] <= '{x: INIT_HEAD_X + 4'd1, y: INIT_HEAD_Y};
            r_mem[2] <= '{x: INIT_HEAD_X,        y: INIT_HEAD_Y};
        end else if (i_push) begin
            r_mem[w_head_nxt] <= i_push_data;
        end
    end

    // Pointer and occupancy-count bookkeeping
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples
        // pre-edge values regardless of statement order.
        if (reset) begin
            r_head_ptr <= AW'(2);
            r_tail_ptr <= '0;
            r_count    <= 9'd3;
        end else begin
            if (i_push) r_head_ptr <= w_head_nxt;
            if (i_pop)  r_tail_ptr <= r_tail_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 9'd1;
                2'b01:   r_count <= r_count - 9'd1;
                default: ;
            endcase
        end
    end

    assign o_head  = r_mem[r_head_ptr];
    assign o_tail  = r_mem[r_tail_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game-step sequencer for a 16x16 red/green LED playfield.
// Per tick: apply latched direction, test wall/self collision and apple capture,
// then issue head / body / tail-erase draw commands over a valid/ready handshake.
// Build option: define SNAKE_WRAP_EN to wrap moves across edges instead of ending the game.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = 64,
    parameter int INIT_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       dir_valid,
    input  logic [1:0] dir,
    input  logic [3:0] apple_x,
    input  logic [3:0] apple_y,
    output logic       draw_valid,
    input  logic       draw_ready,
    output logic [3:0] draw_x,
    output logic [3:0] draw_y,
    output logic [1:0] draw_color,
    output logic [3:0] head_x,
    output logic [3:0] head_y,
    output logic [8:0] length,
    output logic [7:0] score,
    output logic       apple_eaten,
    output logic       busy,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_STEP, S_DRAW_HEAD, S_DRAW_BODY, S_ERASE_TAIL, S_OVER
    } state_e;

    state_e       r_state;
    dir_e         r_cur_dir;
    dir_e         r_pending_dir;
    logic [255:0] r_occ;
    coord_t       r_nxt;
    coord_t       r_old_head;
    logic         r_grow;
    logic [8:0]   r_length;
    logic [7:0]   r_score;
    logic         r_game_over;
    logic         r_draw_valid;
    coord_t       r_draw_pos;
    color_e       r_draw_color;
    logic [1:0]   r_init_idx;

    coord_t       w_head;
    coord_t       w_tail;
    coord_t       w_nxt;
    logic [8:0]   w_count;
    logic         w_wall;
    logic         w_apple_hit;
    logic         w_grow;
    logic         w_hit;
    logic         w_push;
    logic         w_pop;
    logic         w_accept;

    snake_body_fifo #(.MAX_LEN(MAX_LEN)) u_body (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_nxt),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_tail      (w_tail),
        .o_count     (w_count)
    );

    // Candidate head one cell along the pending direction (4-bit arithmetic wraps mod 16)
    always_comb begin
        // NOTE: defaulting every output first guarantees no latch on an uncovered path.
        w_nxt = w_head;
        case (r_pending_dir)
            UP:      w_nxt.y = w_head.y - 4'd1;
            DOWN:    w_nxt.y = w_head.y + 4'd1;
            LEFT:    w_nxt.x = w_head.x - 4'd1;
            RIGHT:   w_nxt.x = w_head.x + 4'd1;
            default: ;
        endcase
    end

`ifdef SNAKE_WRAP_EN
    assign w_wall = 1'b0;
`else
    // Stepping off any edge is a wall hit
    always_comb begin
        w_wall = 1'b0;
        case (r_pending_dir)
            UP:      w_wall = (w_head.y == 4'd0);
            DOWN:    w_wall = (w_head.y == 4'd15);
            LEFT:    w_wall = (w_head.x == 4'd0);
            RIGHT:   w_wall = (w_head.x == 4'd15);
            default: ;
        endcase
    end
`endif

    // Moving into the tail cell is legal when the tail vacates this step (no growth)
    assign w_apple_hit = (w_nxt.x == apple_x) && (w_nxt.y == apple_y);
    assign w_grow      = w_apple_hit && (w_count < 9'(MAX_LEN));
    assign w_hit       = w_wall || (r_occ[{w_nxt.y, w_nxt.x}] && !((w_nxt == w_tail) && !w_grow));
    assign w_accept    = r_draw_valid && draw_ready;
    assign w_push      = (r_state == S_STEP) && !w_hit;
    assign w_pop       = (r_state == S_ERASE_TAIL) && w_accept;

    // Direction latch: last request wins, a reversal of the current heading is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending_dir <= LEFT;
        end else if (dir_valid && (r_state != S_OVER) && (dir_e'(dir) != opposite(r_cur_dir))) begin
            r_pending_dir <= dir_e'(dir);
        end
    end

    // Game-step FSM with occupancy map, score/length and the registered draw command
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_INIT;
            r_cur_dir    <= LEFT;
            r_occ        <= '0;
            r_occ[{INIT_HEAD_Y, INIT_HEAD_X}]          <= 1'b1;
            r_occ[{INIT_HEAD_Y, INIT_HEAD_X + 4'd1}]   <= 1'b1;
            r_occ[{INIT_HEAD_Y, INIT_HEAD_X + 4'd2}]   <= 1'b1;
            r_nxt        <= '0;
            r_old_head   <= '0;
            r_grow       <= 1'b0;
            r_length     <= 9'(INIT_LEN);
            r_score      <= '0;
            r_game_over  <= 1'b0;
            r_draw_valid <= 1'b0;
            r_draw_pos   <= '0;
            r_draw_color <= OFF;
            r_init_idx   <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (!r_draw_valid || draw_ready) begin
                        if (r_init_idx == 2'(INIT_LEN)) begin
                            r_draw_valid <= 1'b0;
                            r_state      <= S_IDLE;
                        end else begin
                            r_draw_valid <= 1'b1;
                            r_draw_pos   <= '{x: INIT_HEAD_X + {2'b00, r_init_idx}, y: INIT_HEAD_Y};
                            r_draw_color <= (r_init_idx == 2'd0) ? GRN : YEL;
                            r_init_idx   <= r_init_idx + 2'd1;
                        end
                    end
                end
                S_IDLE: begin
                    if (tick) r_state <= S_STEP;
                end
                S_STEP: begin
                    r_cur_dir <= r_pending_dir;
                    if (w_hit) begin
                        r_game_over <= 1'b1;
                        r_state     <= S_OVER;
                    end else begin
                        r_occ[{w_nxt.y, w_nxt.x}] <= 1'b1;
                        r_nxt        <= w_nxt;
                        r_old_head   <= w_head;
                        r_grow       <= w_grow;
                        if (w_apple_hit && (r_score != 8'hFF)) r_score <= r_score + 8'd1;
                        if (w_grow) r_length <= r_length + 9'd1;
                        r_draw_valid <= 1'b1;
                        r_draw_pos   <= w_nxt;
                        r_draw_color <= GRN;
                        r_state      <= S_DRAW_HEAD;
                    end
                end
                S_DRAW_HEAD: begin
                    if (w_accept) begin
                        r_draw_pos   <= r_old_head;
                        r_draw_color <= YEL;
                        r_state      <= S_DRAW_BODY;
                    end
                end
                S_DRAW_BODY: begin
                    if (w_accept) begin
                        if (r_grow) begin
                            r_draw_valid <= 1'b0;
                            r_state      <= S_IDLE;
                        end else begin
                            r_draw_pos   <= w_tail;
                            r_draw_color <= OFF;
                            r_state      <= S_ERASE_TAIL;
                        end
                    end
                end
                S_ERASE_TAIL: begin
                    if (w_accept) begin
                        // The new head may sit on the vacated tail cell; keep it occupied then
                        if (w_tail != r_nxt) r_occ[{w_tail.y, w_tail.x}] <= 1'b0;
                        r_draw_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end
                end
                S_OVER: ;
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign draw_valid  = r_draw_valid;
    assign draw_x      = r_draw_pos.x;
    assign draw_y      = r_draw_pos.y;
    assign draw_color  = r_draw_color;
    assign head_x      = w_head.x;
    assign head_y      = w_head.y;
    assign length      = r_length;
    assign score       = r_score;
    assign apple_eaten = (r_state == S_STEP) && !w_hit && w_apple_hit;
    assign busy        = (r_state != S_IDLE);
    assign game_over   = r_game_over;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scoreboard bench for snake_game_ctrl: expected draws are queued as each step is issued;
// a negedge monitor pops and compares every accepted draw command.
module tb_snake_game_ctrl;

    typedef struct packed { logic [3:0] x; logic [3:0] y; logic [1:0] c; } draw_t;
    typedef struct packed { logic [3:0] x; logic [3:0] y; } cell_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       dir_valid = 1'b0;
    logic [1:0] dir = 2'd0;
    logic [3:0] apple_x = 4'd0;
    logic [3:0] apple_y = 4'd0;
    logic       draw_ready = 1'b1;
    logic       draw_valid;
    logic [3:0] draw_x, draw_y, head_x, head_y;
    logic [1:0] draw_color;
    logic [8:0] length;
    logic [7:0] score;
    logic       apple_eaten, busy, game_over;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_eat    = 0;
    int    exp_score = 0;
    int    exp_len   = 3;
    draw_t exp_q[$];
    cell_t body_q[$];
    draw_t mon_e;

    snake_game_ctrl dut (
        .clk(clk), .reset(reset), .tick(tick), .dir_valid(dir_valid), .dir(dir),
        .apple_x(apple_x), .apple_y(apple_y), .draw_valid(draw_valid), .draw_ready(draw_ready),
        .draw_x(draw_x), .draw_y(draw_y), .draw_color(draw_color), .head_x(head_x),
        .head_y(head_y), .length(length), .score(score), .apple_eaten(apple_eaten),
        .busy(busy), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: count apple pulses and score every accepted draw against the queue
    always @(negedge clk) begin
        if (!reset) begin
            if (apple_eaten) n_eat++;
            if (draw_valid && draw_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_draw: got (%0d,%0d) color %0d, expected no draw",
                             draw_x, draw_y, draw_color);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("draw", {draw_x, draw_y, draw_color}, mon_e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_draw(input cell_t p, input logic [1:0] c);
        exp_q.push_back({p.x, p.y, c});
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            cyc();
            n++;
        end
        check(name, busy, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1; tick = 1'b0; dir_valid = 1'b0; draw_ready = 1'b1;
        cyc(); cyc();
        check("rst_draw_valid", draw_valid, 1'b0);
        check("rst_head", {head_x, head_y}, 8'h86);
        check("rst_length", length, 9'd3);
        check("rst_score", score, 8'd0);
        check("rst_apple_eaten", apple_eaten, 1'b0);
        check("rst_game_over", game_over, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_queue_drained", exp_q.size(), 0);
        exp_q.delete();
        body_q.delete();
        body_q.push_back('{4'd8, 4'd6});
        body_q.push_back('{4'd9, 4'd6});
        body_q.push_back('{4'd10, 4'd6});
        exp_score = 0;
        exp_len   = 3;
        expect_draw('{4'd8, 4'd6}, 2'b01);
        expect_draw('{4'd9, 4'd6}, 2'b11);
        expect_draw('{4'd10, 4'd6}, 2'b11);
        reset = 1'b0;
        wait_idle("init_idle", 20);
        check("init_length", length, 9'd3);
        check("init_draws_done", exp_q.size(), 0);
    endtask

    task automatic set_dir(input logic [1:0] d);
        dir = d; dir_valid = 1'b1;
        cyc();
        dir_valid = 1'b0;
    endtask

    // Legal step to (nx,ny); eat means the apple sits on (nx,ny) and the snake grows
    task automatic step_ok(input string name, input logic [3:0] nx, input logic [3:0] ny, input bit eat);
        int    cyc_n;
        int    eat0;
        cell_t nh;
        nh = '{nx, ny};
        expect_draw(nh, 2'b01);
        expect_draw(body_q[0], 2'b11);
        if (!eat) expect_draw(body_q[$], 2'b00);
        body_q.push_front(nh);
        if (!eat) void'(body_q.pop_back());
        if (eat) begin
            exp_score++;
            exp_len++;
        end
        eat0 = n_eat;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc_n = 1;
        while (busy && cyc_n < 40) begin
            cyc();
            cyc_n++;
        end
        check({name, "_cycles"}, cyc_n, eat ? 4 : 5);
        check({name, "_head"}, {head_x, head_y}, {nx, ny});
        check({name, "_length"}, length, exp_len);
        check({name, "_score"}, score, exp_score);
        check({name, "_eat_pulses"}, n_eat - eat0, eat ? 1 : 0);
        check({name, "_draws_done"}, exp_q.size(), 0);
    endtask

    // Step that must end the game: no draws, head unchanged, absorbing afterwards
    task automatic step_over(input string name);
        int eat0;
        eat0 = n_eat;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        repeat (8) cyc();
        check({name, "_game_over"}, game_over, 1'b1);
        check({name, "_busy"}, busy, 1'b1);
        check({name, "_head"}, {head_x, head_y}, {body_q[0].x, body_q[0].y});
        check({name, "_length"}, length, exp_len);
        check({name, "_eat_pulses"}, n_eat - eat0, 0);
        set_dir(2'd0);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        repeat (8) cyc();
        check({name, "_absorbing"}, {game_over, head_x, head_y}, {1'b1, body_q[0].x, body_q[0].y});
    endtask

    initial begin
        // Game 1: basic stepping, growth, direction latch, stall, edge
        do_reset();
        apple_x = 4'd0; apple_y = 4'd0;
        step_ok("plain_step", 4'd7, 4'd6, 1'b0);
        apple_x = 4'd6; apple_y = 4'd6;
        step_ok("grow", 4'd6, 4'd6, 1'b1);
        apple_x = 4'd0; apple_y = 4'd0;
        set_dir(2'd3);                       // RIGHT while heading LEFT: dropped
        step_ok("reverse_dropped", 4'd5, 4'd6, 1'b0);
        set_dir(2'd0);                       // UP, then DOWN: last request wins
        set_dir(2'd1);
        step_ok("last_dir_wins", 4'd5, 4'd7, 1'b0);

        // Back-pressure: hold draw_ready low through DRAW_HEAD, pulse a tick meanwhile
        draw_ready = 1'b0;
        expect_draw('{4'd5, 4'd8}, 2'b01);
        expect_draw(body_q[0], 2'b11);
        expect_draw(body_q[$], 2'b00);
        body_q.push_front('{4'd5, 4'd8});
        void'(body_q.pop_back());
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        for (int i = 0; i < 10; i++) begin
            check("stall_hold", {draw_valid, draw_x, draw_y, draw_color}, {1'b1, 4'd5, 4'd8, 2'b01});
            tick = (i == 3);
            cyc();
        end
        tick = 1'b0;
        draw_ready = 1'b1;
        wait_idle("stall_resume_idle", 20);
        repeat (4) cyc();
        check("stall_tick_not_queued", busy, 1'b0);
        check("stall_head", {head_x, head_y}, 8'h58);
        check("stall_draws_done", exp_q.size(), 0);

        // Steer to the left edge, then push past it
        set_dir(2'd2);
        step_ok("to_edge_4", 4'd4, 4'd8, 1'b0);
        step_ok("to_edge_3", 4'd3, 4'd8, 1'b0);
        step_ok("to_edge_2", 4'd2, 4'd8, 1'b0);
        step_ok("to_edge_1", 4'd1, 4'd8, 1'b0);
        step_ok("to_edge_0", 4'd0, 4'd8, 1'b0);
`ifdef SNAKE_WRAP_EN
        step_ok("edge_wrap", 4'd15, 4'd8, 1'b0);
`else
        step_over("wall_hit");
`endif

        // Game 2: move into the vacating tail, then run into the body
        do_reset();
        apple_x = 4'd7; apple_y = 4'd6;
        step_ok("g2_grow1", 4'd7, 4'd6, 1'b1);
        apple_x = 4'd0; apple_y = 4'd0;
        set_dir(2'd1);
        step_ok("g2_down", 4'd7, 4'd7, 1'b0);
        set_dir(2'd3);
        step_ok("g2_right", 4'd8, 4'd7, 1'b0);
        set_dir(2'd0);
        step_ok("g2_into_tail", 4'd8, 4'd6, 1'b0);
        apple_x = 4'd8; apple_y = 4'd5;
        step_ok("g2_grow2", 4'd8, 4'd5, 1'b1);
        apple_x = 4'd0; apple_y = 4'd0;
        set_dir(2'd2);
        step_ok("g2_left", 4'd7, 4'd5, 1'b0);
        set_dir(2'd1);
        step_ok("g2_down2", 4'd7, 4'd6, 1'b0);
        set_dir(2'd3);
        step_over("self_hit");

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
